// File: rtl/riscv_pkg.sv
// Shared integer-pipeline constants for the writeback stage and register file.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic RESULT_SRC_ALU = 1'b0;
  localparam logic RESULT_SRC_MEM = 1'b1;

  localparam logic [REG_AW-1:0] REG_X0 = '0;

  function automatic logic isCommit(input logic we, input logic [REG_AW-1:0] rd);
    return we && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write integer register file with hardwired x0.
// Same-cycle write-to-read bypass is enabled by defining WB_BYPASS_EN.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] wAddr,
  input  logic [XLEN-1:0]   wData,
  input  logic [REG_AW-1:0] rAddr1,
  input  logic [REG_AW-1:0] rAddr2,
  output logic [XLEN-1:0]   rData1,
  output logic [XLEN-1:0]   rData2
);

  logic [XLEN-1:0] regs [NREGS];

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (isCommit(we, wAddr)) begin
      regs[wAddr] <= wData;
    end
  end

`ifdef WB_BYPASS_EN
  logic writeLive;
  assign writeLive = isCommit(we, wAddr);
`endif

  always_comb begin
    rData1 = '0;
    rData2 = '0;
    if (rst_n) begin
      if (rAddr1 != REG_X0) rData1 = regs[rAddr1];
      if (rAddr2 != REG_X0) rData2 = regs[rAddr2];
`ifdef WB_BYPASS_EN
      if (writeLive && (rAddr1 == wAddr)) rData1 = wData;
      if (writeLive && (rAddr2 == wAddr)) rData2 = wData;
`endif
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register-file commit, commit trace and counter.
// Optional macro WB_BYPASS_EN makes a W-stage write visible to same-cycle decode reads.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteW,
  input  logic              ResultSrcW,
  input  logic [XLEN-1:0]   ALUResultW,
  input  logic [XLEN-1:0]   ReadDataW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [REG_AW-1:0] A1D,
  input  logic [REG_AW-1:0] A2D,
  output logic [XLEN-1:0]   RD1D,
  output logic [XLEN-1:0]   RD2D,
  output logic [XLEN-1:0]   ResultW,
  output logic              CommitValid,
  output logic [REG_AW-1:0] CommitRd,
  output logic [XLEN-1:0]   CommitData,
  output logic [XLEN-1:0]   WbCount
);

  logic commitNow;

  assign ResultW   = (ResultSrcW == RESULT_SRC_MEM) ? ReadDataW : ALUResultW;
  assign commitNow = isCommit(RegWriteW, RdW);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) regFile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (RegWriteW),
    .wAddr  (RdW),
    .wData  (ResultW),
    .rAddr1 (A1D),
    .rAddr2 (A2D),
    .rData1 (RD1D),
    .rData2 (RD2D)
  );

  // Rd/data hold their last committed values so the trace stays readable between commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CommitValid <= 1'b0;
      CommitRd    <= '0;
      CommitData  <= '0;
    end else begin
      CommitValid <= commitNow;
      if (commitNow) begin
        CommitRd   <= RdW;
        CommitData <= ResultW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WbCount <= '0;
    end else if (commitNow) begin
      WbCount <= WbCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile; a narrow 8-bit instance exercises counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [4:0]  A1D;
  logic [4:0]  A2D;
  logic [31:0] RD1D, RD2D, ResultW, CommitData, WbCount;
  logic        CommitValid;
  logic [4:0]  CommitRd;

  logic [7:0]  rd1Narrow, rd2Narrow, resultNarrow, commitDataNarrow, wbCountNarrow;
  logic        commitValidNarrow;
  logic [4:0]  commitRdNarrow;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] regModel [32];
  logic        lastValid;
  logic [4:0]  lastRd;
  logic [31:0] lastData;
  int unsigned commitsTotal;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk (clk), .rst_n (rst_n), .RegWriteW (RegWriteW), .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW), .ReadDataW (ReadDataW), .RdW (RdW), .A1D (A1D), .A2D (A2D),
    .RD1D (RD1D), .RD2D (RD2D), .ResultW (ResultW), .CommitValid (CommitValid),
    .CommitRd (CommitRd), .CommitData (CommitData), .WbCount (WbCount)
  );

  wb_regfile #(.XLEN(8)) dutNarrow (
    .clk (clk), .rst_n (rst_n), .RegWriteW (RegWriteW), .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW[7:0]), .ReadDataW (ReadDataW[7:0]), .RdW (RdW), .A1D (A1D),
    .A2D (A2D), .RD1D (rd1Narrow), .RD2D (rd2Narrow), .ResultW (resultNarrow),
    .CommitValid (commitValidNarrow), .CommitRd (commitRdNarrow),
    .CommitData (commitDataNarrow), .WbCount (wbCountNarrow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] addr, input logic live,
                                          input logic [4:0] rd, input logic [31:0] result);
    if (addr == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (live && addr == rd) return result;
`endif
    return regModel[addr];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) regModel[i] = 32'd0;
    lastValid    = 1'b0;
    lastRd       = 5'd0;
    lastData     = 32'd0;
    commitsTotal = 0;
  endtask

  // One W-stage cycle: drive, check combinational reads, clock, check trace and counter.
  task automatic applyStimulus(input logic we, input logic src, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [4:0] rd,
                               input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] result;
    logic        live;
    RegWriteW = we; ResultSrcW = src; ALUResultW = alu; ReadDataW = mem;
    RdW = rd; A1D = a1; A2D = a2;
    #1;
    result = src ? mem : alu;
    live   = we && (rd != 5'd0);
    checkOutput("ResultW", ResultW, result);
    checkOutput("RD1D_pre", RD1D, expRead(a1, live, rd, result));
    checkOutput("RD2D_pre", RD2D, expRead(a2, live, rd, result));
    @(posedge clk);
    #1;
    if (live) begin
      regModel[rd] = result;
      lastRd       = rd;
      lastData     = result;
      commitsTotal++;
    end
    lastValid = live;
    checkOutput("CommitValid", {31'd0, CommitValid}, {31'd0, lastValid});
    checkOutput("CommitRd", {27'd0, CommitRd}, {27'd0, lastRd});
    checkOutput("CommitData", CommitData, lastData);
    checkOutput("WbCount", WbCount, commitsTotal);
    checkOutput("WbCountNarrow", {24'd0, wbCountNarrow}, commitsTotal % 256);
    checkOutput("RD1D_post", RD1D, expRead(a1, live, rd, result));
  endtask

  initial begin
    rst_n = 1'b0;
    RegWriteW = 1'b1; ResultSrcW = 1'b0; ALUResultW = 32'hA5A5_A5A5; ReadDataW = 32'd0;
    RdW = 5'd5; A1D = 5'd5; A2D = 5'd5;
    clearModel();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_RD1D", RD1D, 32'd0);
    checkOutput("rst_CommitValid", {31'd0, CommitValid}, 32'd0);
    checkOutput("rst_WbCount", WbCount, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);

    // ALU writeback, then read back while the trace shows the commit
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd7, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    checkOutput("alu_x7", RD1D, 32'h0000_1234);

    applyStimulus(1'b1, 1'b1, 32'h55, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd0);
    checkOutput("load_x3", RD1D, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_read", RD1D, 32'd0);
    checkOutput("x0_count", WbCount, 32'd2);

    applyStimulus(1'b1, 1'b0, 32'h11, 32'h0, 5'd9, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 32'h22, 32'h0, 5'd9, 5'd9, 5'd9);
    checkOutput("bypass_post", RD2D, 32'h22);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    5'($urandom), 5'($urandom));
    end

    // Drive the narrow counter to its top value, then across the wrap
    while ((commitsTotal % 256) != 255) begin
      applyStimulus(1'b1, 1'b0, $urandom, 32'h0, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
    end
    checkOutput("wrap_top", {24'd0, wbCountNarrow}, 32'hFF);
    applyStimulus(1'b1, 1'b0, 32'h77, 32'h0, 5'd12, 5'd12, 5'd0);
    checkOutput("wrap_zero", {24'd0, wbCountNarrow}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h88, 5'd13, 5'd13, 5'd12);
    checkOutput("wrap_one", {24'd0, wbCountNarrow}, 32'h1);
    checkOutput("wrap_valid", {31'd0, commitValidNarrow}, 32'd1);

    // Reset asserted mid-cycle with a write pending clears everything at once
    RegWriteW = 1'b1; ResultSrcW = 1'b0; ALUResultW = 32'hCAFE_0001; RdW = 5'd5;
    A1D = 5'd5; A2D = 5'd13;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_RD1D", RD1D, 32'd0);
    checkOutput("midrst_RD2D", RD2D, 32'd0);
    checkOutput("midrst_CommitValid", {31'd0, CommitValid}, 32'd0);
    checkOutput("midrst_CommitData", CommitData, 32'd0);
    checkOutput("midrst_WbCount", WbCount, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_hold_RD1D", RD1D, 32'd0);
    rst_n = 1'b1;
    clearModel();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd13);
    checkOutput("postrst_x5", RD1D, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0BAD_F00D, 32'd0, 5'd31, 5'd31, 5'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
